// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO.
// A queued byte starts its frame one cycle after it is written; frames run back to back.
module uart_tx_fifo #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       new_data,
    input  logic       block,
    output logic       busy,
    output logic       idle,
    output logic       tx
);
    localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;

    logic push, pop, bit_end, can_start;

    // busy reflects the count before the edge, so a write while full is dropped even if a pop coincides
    assign busy      = (count_q == CNT_FULL);
    assign idle      = (state_q == IDLE) && (count_q == '0);
    assign tx        = tx_q;
    assign push      = new_data && !busy && !rst;
    assign bit_end   = (cnt_q == CNT_LAST);
    assign can_start = (count_q != '0) && !block;
    assign pop       = can_start && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is read asynchronously so a byte written at one edge can be popped at the next
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pop) begin
                        state_q <= START;
                        shift_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (pop) begin
                            state_q <= START;
                            shift_q <= mem_q[rd_ptr_q];
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 868, giving clk cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of queued bytes; legal values 2, 4, 8, 16.
REQ-003 The block SHALL have port clk, input, 1, 100 MHz system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port data, input, 8, byte to transmit; sampled when new_data is high.
REQ-006 The block SHALL have port new_data, input, 1, single-cycle write strobe for data.
REQ-007 The block SHALL have port block, input, 1, hold-off; while high, no new frame starts.
REQ-008 The block SHALL have port busy, output, 1, high when FIFO holds FIFO_DEPTH bytes (full).
REQ-009 The block SHALL have port idle, output, 1, high when FIFO is empty and no frame is in progress.
REQ-010 The block SHALL have port tx, output, 1, serial line toward usb_tx; registered, idle-high.

Function
REQ-011 The frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLK_PER_BIT cycles.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP; transitions IDLE->START on pop, START->DATA after CLK_PER_BIT cycles, DATA->STOP after 8 bits, STOP->START (FIFO non-empty and block low) or STOP->IDLE otherwise, at stop-bit end.
REQ-013 A byte written at edge N into an empty FIFO with FSM in IDLE and block low SHALL be popped at edge N+1, with tx low from edge N+1 (one-cycle latency).
REQ-014 Back-to-back frames SHALL have zero idle cycles between stop bit end and next start bit.
REQ-015 A bit counter SHALL count 0..CLK_PER_BIT-1 with width ceil(log2(CLK_PER_BIT)); bit index 0..7 (3 bits); no wrap beyond range.
REQ-016 FIFO SHALL be a circular buffer with wrap-around read/write pointers and a count of width log2(FIFO_DEPTH)+1.
REQ-017 busy SHALL be combinational from count == FIFO_DEPTH; new_data while busy high SHALL drop the byte with no change to FIFO contents or pointers.
REQ-018 Simultaneous write and pop (not full) SHALL leave count unchanged and preserve byte order.
REQ-019 A write while full coincident with a pop SHALL still be dropped (busy evaluated before the edge).
REQ-020 block SHALL be evaluated only at IDLE and at stop-bit end; a frame in progress SHALL always complete.
REQ-021 data SHALL be latched into the shift register on pop; later FIFO activity SHALL not corrupt the frame.

Reset
REQ-022 On rst high at an edge: tx=1, busy=0, idle=1, FSM=IDLE, counters and pointers 0, FIFO empty.
REQ-023 Reset mid-frame SHALL abort the frame: tx=1 from that edge, queued bytes discarded.
REQ-024 new_data asserted in the same cycle as rst SHALL be ignored.

Verification (CLK_PER_BIT=4, FIFO_DEPTH=4)
REQ-025 Write 0xA5 once from reset -> tx from next edge: 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total), then idle=1.
REQ-026 Write 0x01,0x02,0x03 on consecutive cycles -> three contiguous frames, 120 cycles, no gap, order preserved.
REQ-027 Write 6 bytes on consecutive cycles with block high -> busy=1 after 4th, bytes 5-6 dropped; release block -> exactly first 4 bytes sent.
REQ-028 Raise block during frame 1 of 2 queued -> frame 1 completes, tx stays 1 until block low, then frame 2 starts next edge.
REQ-029 Assert rst at cycle 15 of frame 0x55 with 2 bytes queued -> tx=1, idle=1 next edge; nothing transmitted afterward.
REQ-030 Write at the same edge a pop occurs with count=3 -> count remains 3, output order matches write order.
